// File: rtl/draw_dog.sv
// Dog sprite animation FSM, ROM addressing and 2-clk pixel overlay for the VGA chain.
// Optional macro DOG_BIRD_EN enables the dog-with-bird pose and its ROM path.
module draw_dog #(
    parameter int DOG_W        = 44,
    parameter int DOG_H        = 60,
    parameter int BIRD_W       = 40,
    parameter int BIRD_H       = 43,
    parameter int X_START      = 0,
    parameter int X_SNIFF      = 300,
    parameter int Y_GROUND     = 560,
    parameter int WALK_STEP    = 2,
    parameter int ANIM_DIV     = 6,
    parameter int SNIFF_FRAMES = 60,
    parameter int JUMP_FRAMES  = 30,
    parameter int SHOW_FRAMES  = 90,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        bird_hit,
    input  logic        bird_escaped,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] rom_address,
    output logic [3:0]  dog_select,
    input  logic [11:0] rom_rgb,
    output logic [10:0] dog_bird_address,
    input  logic [11:0] dog_bird_rgb,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, WALK, SNIFF, JUMP, WAIT, SHOW_BIRD, LAUGH} state_t;

    state_t      state, state_nx;
    logic [10:0] dog_x, x_nx, dog_y, y_nx, x_step;
    logic [3:0]  sel_nx;
    logic [2:0]  anim_cnt, anim_nx;
    logic [6:0]  frame_cnt, cnt_nx;
    logic        start_pend, pend_nx, esc_flag, esc_nx, hit_flag, hit_nx;
    logic        vblnk_q, frame_tick, anim_wrap;

    assign frame_tick = vblnk_in & ~vblnk_q;
    assign busy       = (state != IDLE) && (state != WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dog_x      <= 11'(X_START);
            dog_y      <= 11'(Y_GROUND);
            dog_select <= 4'd0;
            anim_cnt   <= 3'd0;
            frame_cnt  <= 7'd0;
            start_pend <= 1'b0;
            esc_flag   <= 1'b0;
            hit_flag   <= 1'b0;
            vblnk_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            dog_x      <= x_nx;
            dog_y      <= y_nx;
            dog_select <= sel_nx;
            anim_cnt   <= anim_nx;
            frame_cnt  <= cnt_nx;
            start_pend <= pend_nx;
            esc_flag   <= esc_nx;
            hit_flag   <= hit_nx;
            vblnk_q    <= vblnk_in;
        end
    end

    always_comb begin
        state_nx  = state;
        x_nx      = dog_x;
        y_nx      = dog_y;
        sel_nx    = dog_select;
        anim_nx   = anim_cnt;
        cnt_nx    = frame_cnt;
        pend_nx   = start_pend;
        esc_nx    = esc_flag;
        hit_nx    = hit_flag;
        anim_wrap = (anim_cnt == 3'(ANIM_DIV - 1));
        x_step    = dog_x + 11'(WALK_STEP);
        if (start && (state == IDLE || state == WAIT)) begin
            pend_nx = 1'b1;
            x_nx    = 11'(X_START);
            y_nx    = 11'(Y_GROUND);
        end
        if (frame_tick) begin
            anim_nx = anim_wrap ? 3'd0 : anim_cnt + 3'd1;
            cnt_nx  = frame_cnt + 7'd1;
            case (state)
                IDLE: if (start_pend) begin
                    state_nx = WALK; pend_nx = 1'b0; sel_nx = 4'd0; anim_nx = 3'd0;
                end
                WALK: if (x_step >= 11'(X_SNIFF)) begin
                    state_nx = SNIFF; x_nx = 11'(X_SNIFF);
                    sel_nx = 4'd4; anim_nx = 3'd0; cnt_nx = 7'd0;
                end else begin
                    x_nx = x_step;
                    if (anim_wrap) sel_nx = (dog_select == 4'd3) ? 4'd0 : dog_select + 4'd1;
                end
                SNIFF: if (frame_cnt == 7'(SNIFF_FRAMES - 1)) begin
                    // first jump frame already shows the dog raised
                    state_nx = JUMP; sel_nx = 4'd6; y_nx = dog_y - 11'd3; cnt_nx = 7'd0;
                end else if (anim_wrap) begin
                    sel_nx = (dog_select == 4'd4) ? 4'd5 : 4'd4;
                end
                JUMP: if (frame_cnt == 7'(JUMP_FRAMES - 1)) begin
                    state_nx = WAIT; y_nx = 11'(Y_GROUND);
                end else begin
                    y_nx = dog_y - 11'd3;
                end
                WAIT: if (start_pend) begin
                    state_nx = WALK; pend_nx = 1'b0; sel_nx = 4'd0; anim_nx = 3'd0;
                    hit_nx = 1'b0; esc_nx = 1'b0;
                end else if (hit_flag) begin
                    state_nx = SHOW_BIRD; cnt_nx = 7'd0; hit_nx = 1'b0; esc_nx = 1'b0;
                end else if (esc_flag) begin
                    state_nx = LAUGH; sel_nx = 4'd7; anim_nx = 3'd0; cnt_nx = 7'd0;
                    hit_nx = 1'b0; esc_nx = 1'b0;
                end
                SHOW_BIRD: if (frame_cnt == 7'(SHOW_FRAMES - 1)) state_nx = WAIT;
                LAUGH: if (frame_cnt == 7'(SHOW_FRAMES - 1)) begin
                    state_nx = WAIT;
                end else if (anim_wrap) begin
                    sel_nx = (dog_select == 4'd7) ? 4'd8 : 4'd7;
                end
                default: state_nx = IDLE;
            endcase
        end
        // new events win over the clear on WAIT exit so none is lost
`ifdef DOG_BIRD_EN
        if (bird_hit) hit_nx = 1'b1;
`else
        if (bird_hit) esc_nx = 1'b1;
`endif
        if (bird_escaped) esc_nx = 1'b1;
    end

    logic        bird_act, visible, in_sprite;
    logic [11:0] spr_w, spr_h, spr_y, h12, v12, x12, rel_x, rel_y;

    always_comb begin
`ifdef DOG_BIRD_EN
        bird_act = (state == SHOW_BIRD);
`else
        bird_act = 1'b0;
`endif
        visible   = (state == WALK) || (state == SNIFF) || (state == JUMP) ||
                    (state == SHOW_BIRD) || (state == LAUGH);
        spr_w     = bird_act ? 12'(BIRD_W) : 12'(DOG_W);
        spr_h     = bird_act ? 12'(BIRD_H) : 12'(DOG_H);
        spr_y     = bird_act ? 12'(Y_GROUND) : {1'b0, dog_y};
        h12       = {1'b0, hcount_in};
        v12       = {1'b0, vcount_in};
        x12       = {1'b0, dog_x};
        rel_x     = h12 - x12;
        rel_y     = v12 - spr_y;
        in_sprite = visible && (h12 >= x12) && (h12 < x12 + spr_w) &&
                    (v12 >= spr_y) && (v12 < spr_y + spr_h);
    end

    logic [10:0] vcount_p1, hcount_p1;
    logic        vsync_p1, vblnk_p1, hsync_p1, hblnk_p1, in_p1, bird_p1, in_p2;
    logic [11:0] rgb_p1, rgb_p2, data_p2;

    // stage 1: timing, in-sprite flag and ROM addresses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {vcount_p1, hcount_p1, vsync_p1, vblnk_p1, hsync_p1, hblnk_p1} <= '0;
            rgb_p1           <= 12'd0;
            in_p1            <= 1'b0;
            bird_p1          <= 1'b0;
            rom_address      <= 12'd0;
            dog_bird_address <= 11'd0;
        end else begin
            {vcount_p1, hcount_p1} <= {vcount_in, hcount_in};
            {vsync_p1, vblnk_p1, hsync_p1, hblnk_p1} <= {vsync_in, vblnk_in, hsync_in, hblnk_in};
            rgb_p1      <= rgb_in;
            in_p1       <= in_sprite;
            bird_p1     <= bird_act;
            rom_address <= (in_sprite && !bird_act) ? 12'(rel_y * 12'(DOG_W) + rel_x) : 12'd0;
`ifdef DOG_BIRD_EN
            dog_bird_address <= (in_sprite && bird_act) ? 11'(rel_y * 12'(BIRD_W) + rel_x) : 11'd0;
`else
            dog_bird_address <= 11'd0;
`endif
        end
    end

`ifdef DOG_BIRD_EN
    logic [11:0] sprite_rgb;
    assign sprite_rgb = bird_p1 ? dog_bird_rgb : rom_rgb;
`else
    logic [11:0] sprite_rgb;
    logic        unused_bird;
    assign sprite_rgb  = rom_rgb;
    assign unused_bird = ^{dog_bird_rgb, bird_p1};
`endif

    // stage 2: ROM data aligned with delayed timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {vcount_out, hcount_out, vsync_out, vblnk_out, hsync_out, hblnk_out} <= '0;
            rgb_p2  <= 12'd0;
            in_p2   <= 1'b0;
            data_p2 <= 12'd0;
        end else begin
            {vcount_out, hcount_out} <= {vcount_p1, hcount_p1};
            {vsync_out, vblnk_out, hsync_out, hblnk_out} <= {vsync_p1, vblnk_p1, hsync_p1, hblnk_p1};
            rgb_p2  <= rgb_p1;
            in_p2   <= in_p1;
            data_p2 <= sprite_rgb;
        end
    end

    assign rgb_out = (in_p2 && data_p2 != TRANSPARENT) ? data_p2 : rgb_p2;

endmodule

// File: tb/tb_draw_dog.sv
// Scoreboard bench for draw_dog: stimulus queues expected values, a monitor checks them on their due cycle.
module tb_draw_dog;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 0, bird_hit = 0, bird_escaped = 0;
    logic [10:0] vcount_in = 0, hcount_in = 0;
    logic        vsync_in = 0, vblnk_in = 0, hsync_in = 0, hblnk_in = 0;
    logic [11:0] rgb_in = 0;
    logic [11:0] rom_address, rom_rgb, dog_bird_rgb, rgb_out;
    logic [3:0]  dog_select;
    logic [10:0] dog_bird_address, vcount_out, hcount_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out, busy;
    logic        key = 1'b0;

    // ROM models: dog data = addr+0x100, bird data = addr+0x200, key forces the colour key
    assign rom_rgb      = key ? 12'hF0F : rom_address + 12'h100;
    assign dog_bird_rgb = {1'b0, dog_bird_address} + 12'h200;

    draw_dog dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bird_hit(bird_hit), .bird_escaped(bird_escaped),
        .vcount_in(vcount_in), .hcount_in(hcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .hsync_in(hsync_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
        .rom_address(rom_address), .dog_select(dog_select), .rom_rgb(rom_rgb),
        .dog_bird_address(dog_bird_address), .dog_bird_rgb(dog_bird_rgb),
        .vcount_out(vcount_out), .hcount_out(hcount_out), .vsync_out(vsync_out),
        .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam int K_RGB = 0, K_ADDR = 1, K_BADDR = 2, K_SEL = 3, K_BUSY = 4, K_STATE = 5;
    localparam int K_X = 6, K_Y = 7, K_HC = 8, K_VC = 9, K_SYNC = 10;
    localparam int S_IDLE = 0, S_WALK = 1, S_SNIFF = 2, S_JUMP = 3, S_WAIT = 4, S_BIRD = 5, S_LAUGH = 6;

    typedef struct {
        int          kind;
        int          due;
        logic [11:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    cyc = 0;
    int    n_cmp = 0, n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] actual(int k);
        case (k)
            K_RGB:   return rgb_out;
            K_ADDR:  return rom_address;
            K_BADDR: return {1'b0, dog_bird_address};
            K_SEL:   return {8'd0, dog_select};
            K_BUSY:  return {11'd0, busy};
            K_STATE: return {9'd0, dut.state};
            K_X:     return {1'b0, dut.dog_x};
            K_Y:     return {1'b0, dut.dog_y};
            K_HC:    return {1'b0, hcount_out};
            K_VC:    return {1'b0, vcount_out};
            K_SYNC:  return {8'd0, vsync_out, vblnk_out, hsync_out, hblnk_out};
            default: return 12'hxxx;
        endcase
    endfunction

    // monitor: compare every item whose due cycle has arrived
    initial begin
        item_t       it;
        logic [11:0] a;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                it = sb.pop_front();
                a  = actual(it.kind);
                n_cmp++;
                if (it.due != cyc || a !== it.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h (due cycle %0d, checked %0d)",
                             it.name, a, it.exp, it.due, cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic push(input int k, input int d, input logic [11:0] e, input string n);
        item_t it;
        it.kind = k; it.due = d; it.exp = e; it.name = n;
        sb.push_back(it);
    endtask

    task automatic chk(input int k, input logic [11:0] e, input string n);
        push(k, cyc, e, n);
    endtask

    task automatic frame();
        @(negedge clk) vblnk_in = 1'b1;
        @(negedge clk) vblnk_in = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rin,
                       input logic [11:0] ea, input logic [10:0] eb, input logic [11:0] er);
        @(negedge clk);
        hcount_in = h; vcount_in = v; rgb_in = rin;
        vsync_in = h[0]; hsync_in = h[1]; hblnk_in = h[2];
        push(K_ADDR,  cyc + 1, ea, "rom_address");
        push(K_BADDR, cyc + 1, {1'b0, eb}, "dog_bird_address");
        push(K_RGB,   cyc + 2, er, "rgb_out");
        push(K_HC,    cyc + 2, {1'b0, h}, "hcount_out");
        push(K_VC,    cyc + 2, {1'b0, v}, "vcount_out");
        push(K_SYNC,  cyc + 2, {8'd0, h[0], 1'b0, h[1], h[2]}, "sync_out");
    endtask

    task automatic flush();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk(K_STATE, S_IDLE, "reset_state");
        chk(K_RGB, 12'h000, "reset_rgb");
        chk(K_BUSY, 12'd0, "reset_busy");
        rst_n = 1'b1;

        pulse_start();
        frame();
        chk(K_STATE, S_WALK, "walk_entry");
        chk(K_BUSY, 12'd1, "walk_busy");
        chk(K_X, 12'd0, "walk_x0");
        for (int k = 1; k <= 50; k++) begin
            frame();
            chk(K_SEL, 12'((k / 6) % 4), "walk_sel");
        end
        chk(K_X, 12'd100, "walk_x100");

        pix(105, 562, 12'h123, 12'd93,  11'd0, 12'h15D);
        pix(99,  562, 12'h456, 12'd0,   11'd0, 12'h456);
        pix(143, 619, 12'h789, 12'hA4F, 11'd0, 12'hB4F);
        pix(144, 619, 12'hABC, 12'd0,   11'd0, 12'hABC);
        pix(143, 620, 12'hDEF, 12'd0,   11'd0, 12'hDEF);
        pix(100, 560, 12'h111, 12'd0,   11'd0, 12'h100);
        flush();
        key = 1'b1;
        pix(105, 562, 12'h321, 12'd93, 11'd0, 12'h321);
        flush();
        key = 1'b0;

        @(negedge clk) begin rgb_in = 12'h000; rst_n = 1'b0; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(K_STATE, S_IDLE, "rst_mid_state");
        chk(K_RGB, 12'h000, "rst_mid_rgb");
        chk(K_SEL, 12'd0, "rst_mid_sel");
        chk(K_BUSY, 12'd0, "rst_mid_busy");
        chk(K_X, 12'd0, "rst_mid_x");
        chk(K_Y, 12'd560, "rst_mid_y");

        pulse_start();
        frame();
        chk(K_STATE, S_WALK, "walk2_entry");
        for (int k = 1; k <= 150; k++) begin
            frame();
            if (k < 150) chk(K_SEL, 12'((k / 6) % 4), "walk2_sel");
            if (k == 149) chk(K_X, 12'd298, "walk2_x298");
        end
        chk(K_STATE, S_SNIFF, "sniff_state");
        chk(K_X, 12'd300, "sniff_x");
        chk(K_SEL, 12'd4, "sniff_sel0");
        chk(K_BUSY, 12'd1, "sniff_busy");

        for (int m = 1; m <= 60; m++) begin
            frame();
            if (m < 60) chk(K_SEL, 12'(4 + (m / 6) % 2), "sniff_sel");
        end
        chk(K_STATE, S_JUMP, "jump_state");
        chk(K_SEL, 12'd6, "jump_sel");
        chk(K_Y, 12'd557, "jump_y0");

        for (int j = 1; j <= 30; j++) begin
            if (j == 5) pulse_start();
            frame();
            if (j < 30) begin
                chk(K_Y, 12'(557 - 3 * j), "jump_y");
                chk(K_STATE, S_JUMP, "jump_hold");
            end
            if (j == 29) begin
                pix(300, 470, 12'h0A0, 12'd0, 11'd0, 12'h100);
                pix(300, 469, 12'h0AA, 12'd0, 11'd0, 12'h0AA);
                pix(299, 470, 12'h0BB, 12'd0, 11'd0, 12'h0BB);
                flush();
            end
        end
        chk(K_STATE, S_WAIT, "wait_state");
        chk(K_Y, 12'd560, "wait_y");
        chk(K_BUSY, 12'd0, "wait_busy");
        frame();
        chk(K_STATE, S_WAIT, "jump_start_ignored");
        pix(305, 562, 12'h5A5, 12'd0, 11'd0, 12'h5A5);
        flush();

        @(negedge clk) begin bird_hit = 1'b1; bird_escaped = 1'b1; end
        @(negedge clk) begin bird_hit = 1'b0; bird_escaped = 1'b0; end
        frame();
`ifdef DOG_BIRD_EN
        chk(K_STATE, S_BIRD, "show_bird_state");
        chk(K_BUSY, 12'd1, "show_bird_busy");
        pix(305, 562, 12'h123, 12'd0, 11'd85,   12'h255);
        pix(339, 602, 12'h456, 12'd0, 11'h6B7,  12'h8B7);
        pix(340, 602, 12'h0CC, 12'd0, 11'd0,    12'h0CC);
        pix(339, 603, 12'h0DD, 12'd0, 11'd0,    12'h0DD);
        flush();
        for (int s = 1; s <= 90; s++) begin
            frame();
            if (s < 90) chk(K_STATE, S_BIRD, "show_bird_hold");
        end
`else
        chk(K_STATE, S_LAUGH, "laugh_state");
        chk(K_SEL, 12'd7, "laugh_sel0");
        pix(305, 562, 12'h123, 12'd93, 11'd0, 12'h15D);
        flush();
        for (int l = 1; l <= 90; l++) begin
            frame();
            if (l < 90) begin
                chk(K_SEL, 12'(7 + (l / 6) % 2), "laugh_sel");
                chk(K_STATE, S_LAUGH, "laugh_hold");
            end
            if (l == 45) begin
                pix(310, 570, 12'h222, 12'd450, 11'd0, 12'h2C2);
                flush();
            end
        end
`endif
        chk(K_STATE, S_WAIT, "show_done_wait");
        frame();
        chk(K_STATE, S_WAIT, "flags_cleared");

        pulse_start();
        frame();
        chk(K_STATE, S_WALK, "restart_walk");
        chk(K_X, 12'd0, "restart_x");
        chk(K_SEL, 12'd0, "restart_sel");
        flush();

        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL scoreboard_drain: %0d items left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/draw_dog.md
Name: draw_dog

Overview:
Upstream address/animation stage for the dog sprite ROM, with pixel overlay in the VGA chain. A frame-rate state machine animates the Duck Hunt dog: walk-in, sniff, jump, then show a bird or laugh. Per pixel, the block computes the ROM address and frame select, takes the returned pixel, and overlays it on the incoming VGA stream. It sits between the background stage and the duck/crosshair stages.

Parameters:
DOG_W, 44, sprite width in pixels
DOG_H, 60, sprite height (DOG_W*DOG_H = 2640 words per frame)
BIRD_W, 40, dog-with-bird sprite width
BIRD_H, 43, dog-with-bird sprite height (1720 words)
X_START, 0, walk-in start x
X_SNIFF, 300, x at which walking stops
Y_GROUND, 560, sprite top y while on the ground
WALK_STEP, 2, pixels advanced per frame while walking
ANIM_DIV, 6, frames per animation-frame change
SNIFF_FRAMES, 60, frames spent sniffing
JUMP_FRAMES, 30, frames spent jumping (y -= 3 per frame)
SHOW_FRAMES, 90, frames the bird or laugh pose is shown
TRANSPARENT, 12'hF0F, colour key that is not drawn

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin walk-in sequence
bird_hit  in  1  one-cycle pulse; a duck was shot
bird_escaped  in  1  one-cycle pulse; a duck flew away
vcount_in, hcount_in  in  11 each  VGA counters
vsync_in, vblnk_in, hsync_in, hblnk_in  in  1 each  VGA timing
rgb_in  in  12  upstream pixel
rom_address  out  12  dog ROM address, linear rel_y*DOG_W+rel_x
dog_select  out  4  animation frame 0..8
rom_rgb  in  12  dog ROM data, valid 1 clk after address
dog_bird_address  out  11  bird ROM address, rel_y*BIRD_W+rel_x
dog_bird_rgb  in  12  bird ROM data, valid 1 clk after address
vcount_out, hcount_out  out  11 each  delayed counters
vsync_out, vblnk_out, hsync_out, hblnk_out  out  1 each  delayed timing
rgb_out  out  12  composited pixel
busy  out  1  high in any state other than IDLE and WAIT

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; dog_x=X_START; dog_y=Y_GROUND; latched event flags cleared; counters cleared.
- frame_tick: one-cycle pulse on the rising edge of vblnk_in. State, position and frame counters update only on frame_tick.
- States and transitions (all on frame_tick unless stated):
  - IDLE: hidden. A start pulse at any time sets dog_x=X_START and dog_y=Y_GROUND, then goes to WALK on the next frame_tick.
  - WALK: dog_select cycles 0,1,2,3, advancing every ANIM_DIV frames. dog_x += WALK_STEP. Goes to SNIFF when dog_x >= X_SNIFF (clamped to X_SNIFF).
  - SNIFF: dog_select alternates 4/5 every ANIM_DIV frames. Goes to JUMP after SNIFF_FRAMES.
  - JUMP: dog_select=6; dog_y -= 3 per frame. Goes to WAIT after JUMP_FRAMES; dog_y is then restored to Y_GROUND.
  - WAIT: hidden. On a frame_tick with a latched hit, goes to SHOW_BIRD; else with a latched escape, goes to LAUGH. Both latches clear on exit.
  - SHOW_BIRD: uses the bird sprite at (dog_x, Y_GROUND). Returns to WAIT after SHOW_FRAMES.
  - LAUGH: dog_select alternates 7/8 every ANIM_DIV frames. Returns to WAIT after SHOW_FRAMES.
- Event latching: bird_hit and bird_escaped are latched in any state. If both arrive together, hit wins.
- start is ignored unless the state is IDLE or WAIT. In WAIT it restarts the walk-in.
- Pipeline, fixed 2-clk latency for all VGA outputs:
  - Stage 1 registers timing and rgb, the in-sprite flag, rom_address and dog_bird_address.
  - Stage 2 registers ROM data alongside.
  - rgb_out = stage-2 in-sprite AND data != TRANSPARENT ? data : delayed rgb_in.
- In-sprite condition: hcount in [dog_x, dog_x+W) and vcount in [dog_y, dog_y+H), with W/H chosen by the active sprite. Comparisons use 12-bit sums, so there is no wrap. In hidden states the in-sprite flag is 0.
- Outside the sprite, both addresses are driven to 0.
- dog_select only changes on frame_tick, so it never changes mid-frame.

Optional Feature:
DOG_BIRD_EN
- Defined: SHOW_BIRD state, dog_bird_address output and dog_bird_rgb path are present.
- Undefined: bird_hit is treated as bird_escaped (LAUGH); dog_bird_address is tied to 0; dog_bird_rgb is unused.

Test Plan:
- Reset mid-WALK (rst_n low 3 clk) -> next cycle: state IDLE, rgb_out=0, dog_select=0, busy=0.
- start, then 150 frames -> dog_x=300 and state SNIFF; dog_select has cycled 0..3, changing every 6 frames; busy=1.
- Pixel check in WALK with dog_x=100, dog_y=560, hcount=105, vcount=562 -> rom_address=93 one clk after inputs; rgb_out = rom_rgb 2 clk after inputs. With rom_rgb=12'hF0F -> rgb_out = rgb_in delayed by 2.
- In WAIT, bird_hit and bird_escaped on the same cycle -> SHOW_BIRD at next frame_tick. dog_bird_address = rel_y*40 + rel_x. After 90 frames -> WAIT.
- Build without DOG_BIRD_EN, bird_hit in WAIT -> LAUGH; dog_select alternates 7/8; dog_bird_address stays 0.
- start pulse during JUMP -> ignored. JUMP completes after 30 frames with dog_y dropping 90 px, then WAIT with dog_y=560.
